// File: rtl/scanner_ctrl.sv
// Scanner controller: sequences power-on, standby, scan fill, transfer drain and flush
// of an internally tracked scan buffer, with nearly-full flag and idle auto-standby.
module scanner_ctrl #(
   parameter int PROG_W       = 4,
   parameter int FULL         = 10,
   parameter int READY_AT     = 8,
   parameter int IDLE_TIMEOUT = 16,
   parameter int TO_W         = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              initialOn,
   input  logic              goToStandby,
   input  logic              startScan,
   input  logic              startTransfer,
   input  logic              flush,
   output logic [2:0]        state,
   output logic [PROG_W-1:0] prog,
   output logic              nearlyFull,
   output logic              scanDone,
   output logic              transferDone
);

   typedef enum logic [2:0] {
      ST_OFF          = 3'd0,
      ST_STANDBY      = 3'd1,
      ST_IDLE         = 3'd2,
      ST_SCANNING     = 3'd3,
      ST_TRANSFERRING = 3'd4,
      ST_FLUSHING     = 3'd5
   } state_e;

   localparam logic [PROG_W-1:0] FULL_C     = PROG_W'(FULL);
   localparam logic [PROG_W-1:0] READY_C    = PROG_W'(READY_AT);
   localparam logic [TO_W-1:0]   TIMEOUT_C  = TO_W'(IDLE_TIMEOUT);

   state_e            state_q, state_d;
   logic [PROG_W-1:0] prog_q, prog_d;
   logic [TO_W-1:0]   to_q, to_d, to_inc;
   logic              near_q, scan_done_q, scan_done_d, xfer_done_q, xfer_done_d;
   logic              prog_zero;

   assign prog_zero = (prog_q == '0);
   assign to_inc    = to_q + TO_W'(1);

   // NOTE: every output of this block is assigned a default first, so no latches are inferred.
   always_comb begin
      state_d     = state_q;
      prog_d      = prog_q;
      to_d        = '0;
      scan_done_d = 1'b0;
      xfer_done_d = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (initialOn) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            // Commands whose buffer condition fails are treated as absent.
            if (flush && !prog_zero)              state_d = ST_FLUSHING;
            else if (startTransfer && !prog_zero) state_d = ST_TRANSFERRING;
            else if (startScan && prog_zero)      state_d = ST_SCANNING;
            else if (goToStandby)                 state_d = ST_STANDBY;
            else if (prog_zero) begin
               if (to_inc == TIMEOUT_C) state_d = ST_STANDBY;
               else                     to_d    = to_inc;
            end
         end
         ST_STANDBY: begin
            if (flush && !prog_zero)              state_d = ST_FLUSHING;
            else if (startTransfer && !prog_zero) state_d = ST_TRANSFERRING;
            else if (startScan && prog_zero)      state_d = ST_SCANNING;
         end
         ST_SCANNING: begin
            if (flush) begin
               state_d = ST_FLUSHING;
            end else begin
               if (prog_q < FULL_C) prog_d = prog_q + PROG_W'(1);
               if (prog_d == FULL_C) begin
                  state_d     = ST_IDLE;
                  scan_done_d = 1'b1;
               end
            end
         end
         ST_TRANSFERRING: begin
            if (!prog_zero) prog_d = prog_q - PROG_W'(1);
            if (prog_d == '0) begin
               state_d     = ST_IDLE;
               xfer_done_d = 1'b1;
            end
         end
         ST_FLUSHING: begin
            prog_d  = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_OFF;
            prog_d  = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_OFF;
         prog_q      <= '0;
         to_q        <= '0;
         near_q      <= 1'b0;
         scan_done_q <= 1'b0;
         xfer_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         prog_q      <= prog_d;
         to_q        <= to_d;
         near_q      <= (prog_d >= READY_C);
         scan_done_q <= scan_done_d;
         xfer_done_q <= xfer_done_d;
      end
   end

   assign state        = state_q;
   assign prog         = prog_q;
   assign nearlyFull   = near_q;
   assign scanDone     = scan_done_q;
   assign transferDone = xfer_done_q;

endmodule

// File: doc/scanner_ctrl.md
# scanner_ctrl

- Parametrised scanner controller FSM; next generation of the lab 3 scanner state machine.
- Owns the scan-buffer progress counter internally, so `prog` is an output rather than a bench-driven input.
- Adds configurable capacity, a nearly-full threshold flag, an idle-to-standby timeout, scan abort by flush, and done pulses.
- Sits between the scanner command interface and the inter-scanner transfer/handoff logic.

## Interface

Parameters:
- `PROG_W`, 4: width of the progress counter.
- `FULL`, 10: buffer capacity in units; must satisfy 1 ≤ FULL ≤ 2^PROG_W−1.
- `READY_AT`, 8: nearly-full threshold; must satisfy 1 ≤ READY_AT ≤ FULL.
- `IDLE_TIMEOUT`, 16: consecutive command-free IDLE cycles before auto-standby; must be ≥ 1.
- `TO_W`, 5: timeout counter width; must satisfy 2^TO_W > IDLE_TIMEOUT.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `initialOn` in 1: power-on command.
- `goToStandby` in 1: enter standby.
- `startScan` in 1: begin scan.
- `startTransfer` in 1: begin draining the buffer.
- `flush` in 1: discard buffer contents.
- `state` out 3: current state encoding.
- `prog` out PROG_W: buffer occupancy, 0..FULL.
- `nearlyFull` out 1: high when prog ≥ READY_AT.
- `scanDone` out 1: one-cycle pulse when a scan completes.
- `transferDone` out 1: one-cycle pulse when a transfer completes.

## Operation

State encodings:
- OFF = 0, STANDBY = 1, IDLE = 2, SCANNING = 3, TRANSFERRING = 4, FLUSHING = 5.
- Codes 6 and 7 are illegal; if reached, next state is OFF and prog is 0.

Reset:
- state = OFF, prog = 0, timeout counter = 0.
- nearlyFull = 0, scanDone = 0, transferDone = 0.

Transitions (inputs sampled at posedge). Priority among simultaneous commands: flush > startTransfer > startScan > goToStandby.
- OFF: initialOn → IDLE. All other inputs ignored.
- IDLE:
  - flush with prog ≠ 0 → FLUSHING.
  - startTransfer with prog ≠ 0 → TRANSFERRING.
  - startScan with prog == 0 → SCANNING.
  - goToStandby → STANDBY.
  - timeout expiry with prog == 0 → STANDBY.
  - A command whose prog condition fails is ignored: no state change, and it does not reset the timeout.
- STANDBY:
  - startScan with prog == 0 → SCANNING.
  - startTransfer with prog ≠ 0 → TRANSFERRING.
  - flush with prog ≠ 0 → FLUSHING.
  - goToStandby has no effect.
- SCANNING:
  - prog increments by 1 every cycle.
  - On the edge where prog becomes FULL: state → IDLE, scanDone = 1.
  - flush aborts the scan → FLUSHING; prog holds its current value; no scanDone.
  - All other inputs ignored.
- TRANSFERRING:
  - prog decrements by 1 every cycle.
  - On the edge where prog becomes 0: state → IDLE, transferDone = 1.
  - All inputs ignored, including flush.
- FLUSHING: lasts exactly one cycle; next edge sets prog = 0 and state = IDLE.

Timeout counter:
- Clears on entry to IDLE and on every accepted command.
- Increments each IDLE cycle with no accepted command, only while prog == 0.
- When it reaches IDLE_TIMEOUT, next state is STANDBY.
- Holds at 0 outside IDLE.

Arithmetic rules:
- prog never exceeds FULL and never wraps below 0.
- Increment and decrement use PROG_W-bit unsigned arithmetic.

## Timing

- All outputs are registered and change only on posedge.
- Every command takes effect on the edge at which it is sampled, so `state` changes in the following cycle.
- Scan duration: exactly FULL cycles in SCANNING (prog 1..FULL).
- Transfer duration: exactly FULL cycles from a full buffer; from a partial buffer, prog cycles.
- nearlyFull is updated from the next-state prog, so it is coincident with prog.
- scanDone and transferDone are high for exactly one cycle, coincident with the IDLE state value.
- Reset asserted mid-scan or mid-transfer: on the next edge, all registers return to reset values with no done pulse.
- Command held high across multiple cycles:
  - Held startScan restarts a scan only if prog == 0 when it is sampled in IDLE.
  - Held goToStandby in STANDBY is harmless.

## Test plan

Parameters for all scenarios: FULL = 10, READY_AT = 8, IDLE_TIMEOUT = 4.

1. Power-on: reset 2 cycles, then initialOn for 1 cycle → state 0 then 2. Hold goToStandby 1 cycle → state 1.
2. Full scan: startScan from STANDBY → state 3 for 10 cycles, prog 1..10, nearlyFull rises when prog = 8. Then state 2 with scanDone = 1 for one cycle and prog = 10.
3. Transfer: startTransfer with prog = 10 → state 4 for 10 cycles, prog 9..0, nearlyFull falls when prog = 7. transferDone pulses as state returns to 2. A startScan asserted mid-transfer has no effect.
4. Abort and flush: after a scan reaches prog = 4, assert flush → FLUSHING for 1 cycle, then IDLE with prog = 0 and no scanDone. Assert flush and startTransfer together in IDLE with prog = 10 → FLUSHING wins.
5. Timeout: IDLE with prog = 0 and no inputs → STANDBY after exactly 4 cycles. With prog = 10, no timeout after 20 cycles. startScan with prog = 10 is ignored.
6. Reset mid-scan at prog = 6 → next cycle state = 0, prog = 0, all flags 0.
